// File: rtl/mem_req_engine.sv
// rtl/mem_req_engine.sv - main-memory request sequencer: fill, writeback, writeback+fill with response handshake
module mem_req_engine #(
    parameter int MEM_LAT   = 4,
    parameter int CNT_WIDTH = 16,
    parameter int PA_WIDTH  = 16,
    parameter int BLK_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [PA_WIDTH-1:0]  req_fill_addr,
    input  logic [PA_WIDTH-1:0]  req_wb_addr,
    input  logic [BLK_WIDTH-1:0] req_wb_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BLK_WIDTH-1:0] resp_data,
    output logic                 resp_err,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_data,
    input  logic [BLK_WIDTH-1:0] mem_rd_data,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    output logic [CNT_WIDTH-1:0] wr_cnt
);
    localparam int OFS = $clog2(BLK_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, WB, RD, RESP} state_t;

    state_t               state, state_nxt;
    logic [1:0]           op_q;
    logic [PA_WIDTH-1:0]  fill_addr_q, wb_addr_q;
    logic [BLK_WIDTH-1:0] wb_data_q;
    logic [7:0]           lat_cnt;
    logic                 lat_done;
    logic                 accept;

    assign accept   = (state == IDLE) && req_valid;
    assign lat_done = (lat_cnt == 8'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) begin
                case (req_op)
                    2'b00:   state_nxt = RESP;
                    2'b01:   state_nxt = RD;
                    default: state_nxt = WB;
                endcase
            end
            WB:   if (lat_done) state_nxt = op_q[0] ? RD : RESP;
            RD:   if (lat_done) state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 2'b00;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            lat_cnt     <= '0;
            resp_data   <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
        end else begin
            if (accept) begin
                op_q        <= req_op;
                fill_addr_q <= {req_fill_addr[PA_WIDTH-1:OFS], {OFS{1'b0}}};
                wb_addr_q   <= {req_wb_addr[PA_WIDTH-1:OFS], {OFS{1'b0}}};
                wb_data_q   <= req_wb_data;
            end
            // One shared latency counter; it restarts at each WB->RD handoff.
            if (state == WB || state == RD) lat_cnt <= lat_done ? 8'd0 : lat_cnt + 8'd1;
            else                            lat_cnt <= 8'd0;
            if (state == WB && lat_done && !(&wr_cnt)) wr_cnt <= wr_cnt + 1'b1;
            if (state == RD && lat_done) begin
                resp_data <= mem_rd_data;
                if (!(&rd_cnt)) rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Enables decode straight from state so an async reset drops them at once.
    assign mem_wr_en   = (state == WB);
    assign mem_rd_en   = (state == RD);
    assign mem_addr    = mem_wr_en ? wb_addr_q : (mem_rd_en ? fill_addr_q : '0);
    assign mem_wr_data = mem_wr_en ? wb_data_q : '0;
    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign resp_err    = (state == RESP) && (op_q == 2'b00);
endmodule

// File: tb/tb_mem_req_engine.sv
// tb/tb_mem_req_engine.sv - self-checking bench for mem_req_engine against a transaction-level memory model
module tb_mem_req_engine;
    localparam int LAT = 2;
    localparam int CW  = 3;
    localparam int PW  = 16;
    localparam int BW  = 64;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          req_valid = 0;
    logic          req_ready;
    logic [1:0]    req_op = 0;
    logic [PW-1:0] req_fill_addr = 0;
    logic [PW-1:0] req_wb_addr = 0;
    logic [BW-1:0] req_wb_data = 0;
    logic          resp_valid;
    logic          resp_ready = 0;
    logic [BW-1:0] resp_data;
    logic          resp_err;
    logic [PW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [BW-1:0] mem_wr_data;
    logic [BW-1:0] mem_rd_data;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;

    mem_req_engine #(.MEM_LAT(LAT), .CNT_WIDTH(CW), .PA_WIDTH(PW), .BLK_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_fill_addr(req_fill_addr), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    // Environment memory, driven only by the DUT's memory port.
    logic [BW-1:0] env_mem [0:8191];
    assign mem_rd_data = env_mem[mem_addr[15:3]];
    always @(posedge clk) if (mem_wr_en) env_mem[mem_addr[15:3]] <= mem_wr_data;

    // Reference model state.
    logic [BW-1:0] ref_mem [0:8191];
    logic [BW-1:0] exp_data = '0;
    logic [CW-1:0] exp_rcnt = '0;
    logic [CW-1:0] exp_wcnt = '0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [1:0] op, input logic [PW-1:0] fa, input logic [PW-1:0] wa,
                       input logic [BW-1:0] wd, input int hold);
        int wr_n = 0, rd_n = 0, first_wr = 0, first_rd = 0, resp_at = 0;
        int exp_wr, exp_rd;
        bit overlap = 0, bad_port = 0;
        logic [BW-1:0] snap;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1; req_op = op; req_fill_addr = fa; req_wb_addr = wa; req_wb_data = wd;
        @(posedge clk);
        #1;
        req_valid = 0; req_op = 2'($urandom); req_fill_addr = 16'($urandom);
        req_wb_addr = 16'($urandom); req_wb_data = {$urandom, $urandom};
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_wr_en && mem_rd_en) overlap = 1;
            if (mem_wr_en) begin
                wr_n++;
                if (first_wr == 0) first_wr = c;
                if (mem_addr !== {wa[15:3], 3'b000} || mem_wr_data !== wd) bad_port = 1;
            end else if (mem_rd_en) begin
                rd_n++;
                if (first_rd == 0) first_rd = c;
                if (mem_addr !== {fa[15:3], 3'b000}) bad_port = 1;
            end else if (mem_addr !== '0 || mem_wr_data !== '0) bad_port = 1;
            if (resp_valid) begin
                resp_at = c;
                break;
            end
        end
        exp_wr = op[1] ? LAT : 0;
        exp_rd = op[0] ? LAT : 0;
        if (op[1]) begin
            ref_mem[wa[15:3]] = wd;
            exp_wcnt = (exp_wcnt == CMAX) ? CMAX : exp_wcnt + 1'b1;
        end
        if (op[0]) begin
            exp_data = ref_mem[fa[15:3]];
            exp_rcnt = (exp_rcnt == CMAX) ? CMAX : exp_rcnt + 1'b1;
        end
        chk("resp_latency", 64'(resp_at), 64'(exp_wr + exp_rd + 1));
        chk("wr_cycles", 64'(wr_n), 64'(exp_wr));
        chk("rd_cycles", 64'(rd_n), 64'(exp_rd));
        if (op[1]) chk("first_wr_cycle", 64'(first_wr), 64'd1);
        if (op[0]) chk("first_rd_cycle", 64'(first_rd), 64'(exp_wr + 1));
        chk("enable_overlap", overlap, 1'b0);
        chk("mem_port_values", bad_port, 1'b0);
        chk("resp_err", resp_err, op == 2'b00);
        chk("resp_data", resp_data, exp_data);
        chk("rd_cnt", rd_cnt, exp_rcnt);
        chk("wr_cnt", wr_cnt, exp_wcnt);
        chk("req_ready_resp", req_ready, 1'b0);
        snap = resp_data;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'($urandom);
            @(negedge clk);
            chk("hold_resp_valid", resp_valid, 1'b1);
            chk("hold_resp_data", resp_data, snap);
            chk("hold_req_ready", req_ready, 1'b0);
        end
        req_valid = 0;
        resp_ready = 1;
        @(posedge clk);
        #1 resp_ready = 0;
        @(negedge clk);
        chk("req_ready_after_resp", req_ready, 1'b1);
        chk("resp_valid_drop", resp_valid, 1'b0);
    endtask

    initial begin
        logic [BW-1:0] a5;
        for (int i = 0; i < 8192; i++) begin
            env_mem[i] = {$urandom, $urandom};
            ref_mem[i] = env_mem[i];
        end
        a5 = {8{8'hA5}};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_enables", {mem_rd_en, mem_wr_en}, 2'b00);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_resp_data", resp_data, 64'h0);
        chk("rst_counters", {rd_cnt, wr_cnt}, '0);
        @(negedge clk) rst_n = 1;

        txn(2'b01, 16'h0045, 16'h1234, 64'h0, 0);
        txn(2'b10, 16'h0777, 16'h0080, a5, 0);
        chk("wb_kept_resp_data", resp_data, ref_mem[16'h0045 >> 3]);
        txn(2'b01, 16'h0080, 16'h0000, 64'h0, 0);
        txn(2'b11, 16'h0100, 16'h0100, {$urandom, $urandom}, 0);
        txn(2'b00, 16'h0200, 16'h0300, 64'h1, 0);
        txn(2'b01, 16'h0047, 16'h0000, 64'h0, 5);
        for (int i = 0; i < 24; i++)
            txn(2'($urandom), 16'($urandom), 16'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)));

        // Reset during the read phase.
        @(negedge clk);
        req_valid = 1; req_op = 2'b01; req_fill_addr = 16'h0400;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        chk("rd_phase_before_reset", mem_rd_en, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("reset_drops_rd_en", mem_rd_en, 1'b0);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_resp_valid", resp_valid, 1'b0);
        chk("reset_counters", {rd_cnt, wr_cnt}, '0);
        chk("reset_resp_data", resp_data, 64'h0);
        @(negedge clk) rst_n = 1;
        exp_rcnt = '0; exp_wcnt = '0; exp_data = '0;
        @(negedge clk);
        chk("post_reset_req_ready", req_ready, 1'b1);
        chk("post_reset_resp_valid", resp_valid, 1'b0);
        txn(2'b11, 16'h0500, 16'h0508, {$urandom, $urandom}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
